// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle execute controller driving a 16x8 register file.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int MUL_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  a_sel,
    output logic [3:0]  b_sel,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        wr_en,
    output logic [3:0]  wr_sel,
    output logic [7:0]  wr_data,
    output logic        done,
    output logic        err,
    output logic        zero_flag,
    output logic        carry_flag
);

    localparam int       c_CNT_W  = $clog2(MUL_CYCLES + 1);
    localparam logic [3:0] c_OP_ADD = 4'd1;
    localparam logic [3:0] c_OP_SUB = 4'd2;
    localparam logic [3:0] c_OP_AND = 4'd3;
    localparam logic [3:0] c_OP_OR  = 4'd4;
    localparam logic [3:0] c_OP_XOR = 4'd5;
    localparam logic [3:0] c_OP_SHL = 4'd6;
    localparam logic [3:0] c_OP_SHR = 4'd7;
    localparam logic [3:0] c_OP_LDI = 4'd8;
    localparam logic [3:0] c_OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_instr;
    logic [7:0]           r_op_a;
    logic [7:0]           r_op_b;
    logic [15:0]          r_mcand;
    logic [7:0]           r_mplier;
    logic [15:0]          r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [8:0]           r_result;
    logic                 r_zero;
    logic                 r_carry;

    logic [3:0]           w_op;
    logic                 w_is_mul;
    logic                 w_mul_last;
    logic                 w_writes;
    logic                 w_illegal;
    logic [15:0]          w_acc_next;
    logic [8:0]           w_alu;

    assign w_op       = r_instr[15:12];
    assign w_is_mul   = (w_op == c_OP_MUL);
    assign w_mul_last = (r_cnt == c_CNT_W'(MUL_CYCLES - 1));
    assign w_writes   = (w_op >= c_OP_ADD) && (w_op <= c_OP_MUL);
    assign w_illegal  = (w_op > c_OP_MUL);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 16'd0);

    // Bit 8 carries the carry/borrow that becomes carry_flag in WRITE.
    always_comb begin
        w_alu = 9'd0;
        case (w_op)
            c_OP_ADD: w_alu = {1'b0, r_op_a} + {1'b0, r_op_b};
            c_OP_SUB: w_alu = {(r_op_a < r_op_b), r_op_a - r_op_b};
            c_OP_AND: w_alu = {1'b0, r_op_a & r_op_b};
            c_OP_OR:  w_alu = {1'b0, r_op_a | r_op_b};
            c_OP_XOR: w_alu = {1'b0, r_op_a ^ r_op_b};
            c_OP_SHL: w_alu = {1'b0, r_op_a << r_op_b[2:0]};
            c_OP_SHR: w_alu = {1'b0, r_op_a >> r_op_b[2:0]};
            c_OP_LDI: w_alu = {1'b0, r_instr[7:0]};
            default:  w_alu = 9'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        wr_en        = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_state_next = S_READ;
            end
            S_READ:  w_state_next = S_EXEC;
            S_EXEC: begin
                if (!w_is_mul || w_mul_last) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                done         = 1'b1;
                wr_en        = w_writes;
                err          = w_illegal;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr  <= 16'd0;
            r_op_a   <= 8'd0;
            r_op_b   <= 8'd0;
            r_mcand  <= 16'd0;
            r_mplier <= 8'd0;
            r_acc    <= 16'd0;
            r_cnt    <= '0;
            r_result <= 9'd0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) r_instr <= instr;
                end
                S_READ: begin
                    r_op_a   <= A;
                    r_op_b   <= B;
                    r_mcand  <= {8'd0, A};
                    r_mplier <= B;
                    r_acc    <= 16'd0;
                    r_cnt    <= '0;
                end
                S_EXEC: begin
                    if (w_is_mul) begin
                        // LSB-first shift-add: one multiplier bit per cycle.
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_mul_last) begin
                            r_result <= {(w_acc_next[15:8] != 8'd0), w_acc_next[7:0]};
                        end
                    end else begin
                        r_result <= w_alu;
                    end
                end
                S_WRITE: begin
                    if (w_writes) begin
                        r_zero  <= (r_result[7:0] == 8'd0);
                        r_carry <= r_result[8];
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_sel      = r_instr[7:4];
    assign b_sel      = r_instr[3:0];
    assign wr_sel     = r_instr[11:8];
    assign wr_data    = r_result[7:0];
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

- Multi-cycle execute controller that sits directly upstream of the 16×8 register file.
- Accepts 16-bit instructions over a valid/ready handshake and drives the register-file read selects.
- Captures the two operands, computes an 8-bit result (including an iterative shift-add multiply) and issues a single-cycle write-back.
- Processes one instruction at a time and reports completion, flags and illegal opcodes to the surrounding control logic.

## Interface
Parameters:
- MUL_CYCLES, 8: EXEC-state cycles spent on MUL, one multiplier bit per cycle; must equal the operand width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- instr  in  16  instruction: [15:12] opcode, [11:8] dest, [7:4] srcA, [3:0] srcB (LDI immediate = instr[7:0])
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high only in IDLE; transfer occurs when instr_valid && instr_ready at a clock edge
- a_sel  out  4  register-file read select A = latched srcA
- b_sel  out  4  register-file read select B = latched srcB
- A  in  8  register-file read data A, combinational from a_sel
- B  in  8  register-file read data B, combinational from b_sel
- wr_en  out  1  register-file writeEnable, one-cycle pulse
- wr_sel  out  4  write destination = latched dest
- wr_data  out  8  write-back value
- done  out  1  one-cycle pulse in the final cycle of every accepted instruction
- err  out  1  one-cycle pulse coincident with done for an illegal opcode
- zero_flag  out  1  registered: last flag-updating result == 0
- carry_flag  out  1  registered carry/borrow/overflow of the last flag-updating op

## Operation
- States: IDLE → READ → EXEC → WRITE → IDLE.
- IDLE: instr_ready=1. On handshake, latch instr and go to READ.
- READ: a_sel/b_sel come from the latched instruction. Capture A and B into opA/opB at the end of the cycle, then go to EXEC.
- EXEC, non-MUL ops: compute the 9-bit result into a result register in one cycle, then go to WRITE.
- EXEC, MUL: run MUL_CYCLES iterations of LSB-first shift-add into a 16-bit accumulator, then go to WRITE.
- WRITE: wr_en=1 only for writing opcodes, with wr_sel=dest and wr_data=result[7:0]. Assert done; update flags; return to IDLE.
- Opcodes, with their results and flag updates:
  - 0 NOP: no write; flags unchanged.
  - 1 ADD: A+B; carry = bit 8.
  - 2 SUB: A−B mod 256; carry = borrow (A<B).
  - 3 AND, 4 OR, 5 XOR: bitwise; carry=0.
  - 6 SHL: A << B[2:0]; carry=0.
  - 7 SHR: A >> B[2:0], logical; carry=0.
  - 8 LDI: result = instr[7:0]; operands ignored; carry=0.
  - 9 MUL: result = low byte of A×B; carry = |product[15:8].
  - 10–15 illegal: no write; err=1 with done; flags unchanged.
- zero_flag is updated with carry_flag for opcodes 1–9 only.
- wr_data and wr_sel are driven from registers at all times. Only wr_en qualifies them.
- Same-register cases (dest==srcA or dest==srcB) are safe, because operands are captured in READ before the WRITE cycle.

## Timing
- Handshake at edge E0. READ is cycle 1, EXEC is cycle 2, WRITE (wr_en, done) is cycle 3.
- instr_ready rises in cycle 4, giving one instruction per 4 cycles.
- MUL: EXEC occupies cycles 2..(1+MUL_CYCLES). WRITE falls in cycle 2+MUL_CYCLES (cycle 10 at default), so throughput is one per 11 cycles.
- The register-file write takes effect at the edge ending WRITE. The next instruction's READ is at least 2 cycles later, so there are no hazards.
- instr_valid while busy is ignored. instr may change freely outside the handshake edge.
- Reset (rst=0, asynchronous), for every output:
  - state=IDLE, instr_ready=1.
  - a_sel=b_sel=wr_sel=0, wr_data=0.
  - wr_en=done=err=0, zero_flag=carry_flag=0.
  - Latched instruction, operands and accumulator cleared.
- Reset asserted mid-instruction, including mid-MUL, aborts the instruction: no write, no done.
- After rst deasserts, the first edge may accept an instruction.

## Test plan
- Reset mid-MUL (rst low at cycle 5): outputs zero immediately, no wr_en, instr_ready=1; a new LDI after release completes normally.
- Preload via LDI r1=0xC8, LDI r2=0x64, then ADD r3=r1+r2 → wr_en in cycle 3 after handshake, wr_data=0x2C, wr_sel=3, carry=1, zero=0.
- SUB r4=r2−r1 (0x64−0xC8) → wr_data=0x9C, carry=1. Then SUB r5=r1−r1 → wr_data=0x00, zero=1, carry=0.
- MUL 0x13×0x11 → wr_data=0x43, carry=1 (product 0x0143). wr_en occurs exactly 10 cycles after handshake; instr_valid held high while busy is not accepted early.
- Illegal opcode 0xF, and also NOP → done pulses with no wr_en and flags unchanged; err=1 only for 0xF.
- Back-to-back valid held high with ADD r1=r1+r1 (r1=0x40) twice → results 0x80 then 0x00. The second uses the first's write-back; handshakes occur 4 cycles apart.
